// File: rtl/dot_accumulator_if.sv
// Term/result handshake bundle for dot_accumulator: 8-bit product stream in,
// ACC_W-bit dot-product result out.
interface dot_accumulator_if #(
    parameter int unsigned ACC_W = 16
);
    logic [7:0]       prod;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_valid;
    logic             out_ready;
    logic             out_ovf;

    modport master (
        output prod, in_valid, out_ready,
        input  in_ready, out_sum, out_valid, out_ovf
    );

    modport slave (
        input  prod, in_valid, out_ready,
        output in_ready, out_sum, out_valid, out_ovf
    );
endinterface

// File: rtl/dot_accumulator.sv
// Sums K unsigned 8-bit products into one ACC_W-bit result held until consumed.
// Define DOT_ACC_SAT_EN for saturating accumulation with overflow reporting.
module dot_accumulator #(
    parameter int unsigned K     = 4,
    parameter int unsigned ACC_W = 16
) (
    input logic              clk,
    input logic              rst,
    dot_accumulator_if.slave bus
);
    localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [0:0] {StAccum, StHold} state_t;

    state_t           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] prod_ext;
    logic             accept;
    logic             last;

    assign prod_ext = ACC_W'(bus.prod);
    assign accept   = bus.in_valid && (state_q == StAccum);
    assign last     = (cnt_q == CntW'(K - 1));

`ifdef DOT_ACC_SAT_EN
    logic             sticky_q, sticky_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum_ext;

    assign sum_ext = {1'b0, acc_q} + {1'b0, prod_ext};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
`ifdef DOT_ACC_SAT_EN
        sticky_d = sticky_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    // First term of a group replaces whatever the last group left behind.
                    if (cnt_q == '0) begin
                        acc_d = prod_ext;
`ifdef DOT_ACC_SAT_EN
                        sticky_d = 1'b0;
`endif
                    end else begin
`ifdef DOT_ACC_SAT_EN
                        // Once clamped, any further nonzero term carries again, so it stays clamped.
                        if (sum_ext[ACC_W]) begin
                            acc_d    = '1;
                            sticky_d = 1'b1;
                        end else begin
                            acc_d = sum_ext[ACC_W-1:0];
                        end
`else
                        acc_d = acc_q + prod_ext;
`endif
                    end
                    if (last) begin
                        cnt_d   = '0;
                        state_d = StHold;
                        sum_d   = acc_d;
`ifdef DOT_ACC_SAT_EN
                        ovf_d = sticky_d;
`endif
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccum;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
`ifdef DOT_ACC_SAT_EN
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
`ifdef DOT_ACC_SAT_EN
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == StAccum);
    assign bus.out_valid = (state_q == StHold);
    assign bus.out_sum   = sum_q;
`ifdef DOT_ACC_SAT_EN
    assign bus.out_ovf   = ovf_q;
`else
    assign bus.out_ovf   = 1'b0;
`endif
endmodule
